muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the single-cycle ALU in the execute stage.
- Execute-stage decode asserts start for R-type with funct7 = 0000001.
- The block freezes the pipeline via stall until the result is ready.
- Uses shift-add multiply and restoring divide on operand magnitudes, then applies sign correction in the final cycle.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_core.sv | 57 +++++
 rtl/muldiv_sequencer.sv | 144 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 encodings,
// FSM states and the M-extension funct7 value.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_core.sv
// Datapath for unsigned shift-add multiply and restoring divide on operand magnitudes.
// hi/lo hold partial product + multiplier, or partial remainder + quotient.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    shifted = {hi_reg, lo_reg[WIDTH-1]};
    diff    = shifted - {1'b0, b_reg};
    hi_next = add_sum[WIDTH:1];
    lo_next = {add_sum[0], lo_reg[WIDTH-1:1]};
    if (mode) begin
      // diff[WIDTH] set means the trial subtraction went negative: restore
      if (!diff[WIDTH]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
      b_reg  <= '0;
    end else if (load) begin
      hi_reg <= '0;
      lo_reg <= a_mag;
      b_reg  <= b_mag;
    end else if (step) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: FSM, counter, sign handling and special cases.
// Optional MULDIV_FASTPATH_EN completes trivial operations (x/0, overflow, mul by 0) in one cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH-1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic [2:0]       f3_reg;
  logic             neg_a_reg, neg_b_reg, b_zero_reg, ovf_reg;
  logic [WIDTH-1:0] result_reg;

  logic             signed_a, signed_b, neg_a_in, neg_b_in, b_zero_in, ovf_in;
  logic [WIDTH-1:0] a_mag, b_mag, hi_next, lo_next;
  logic             accept, last_step, fast_hit, result_load;
  logic [WIDTH-1:0] fast_value, final_value, result_value;
  logic [2*WIDTH-1:0] prod, prod_c;

  always_comb begin
    signed_a  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                (funct3 == F3_DIV)  || (funct3 == F3_REM);
    signed_b  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    neg_a_in  = signed_a & op_a[WIDTH-1];
    neg_b_in  = signed_b & op_b[WIDTH-1];
    a_mag     = neg_a_in ? -op_a : op_a;
    b_mag     = neg_b_in ? -op_b : op_b;
    b_zero_in = (op_b == '0);
    ovf_in    = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                (op_a == MIN_NEG) && (op_b == '1);
    accept    = (state_reg == IDLE) && start && !flush;
    last_step = (state_reg == BUSY) && !flush && (count_reg == LAST);
  end

`ifdef MULDIV_FASTPATH_EN
  always_comb begin
    fast_hit = funct3[2] ? (b_zero_in || ovf_in) : ((op_a == '0) || (op_b == '0));
    fast_value = '0;
    if (funct3 == F3_DIV || funct3 == F3_DIVU)
      fast_value = b_zero_in ? '1 : MIN_NEG;
    else if (funct3 == F3_REM || funct3 == F3_REMU)
      fast_value = b_zero_in ? op_a : '0;
  end
`else
  always_comb begin
    fast_hit   = 1'b0;
    fast_value = '0;
  end
`endif

  // Corrected result from the values the core is about to register on its final step.
  always_comb begin
    prod   = {hi_next, lo_next};
    prod_c = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
    case (f3_reg)
      F3_MUL:              final_value = prod_c[WIDTH-1:0];
      F3_MULH, F3_MULHSU,
      F3_MULHU:            final_value = prod_c[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU: begin
        if (b_zero_reg)   final_value = '1;
        else if (ovf_reg) final_value = MIN_NEG;
        else              final_value = (neg_a_reg ^ neg_b_reg) ? -lo_next : lo_next;
      end
      // With a zero divisor every step shifts the dividend into hi unchanged, so rem = op_a
      default:             final_value = ovf_reg ? '0 : (neg_a_reg ? -hi_next : hi_next);
    endcase
    result_load  = last_step || (accept && fast_hit);
    result_value = (state_reg == IDLE) ? fast_value : final_value;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = fast_hit ? DONE : BUSY;
      BUSY: begin
        if (flush)                  state_next = IDLE;
        else if (count_reg == LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    stall = !flush && (((state_reg == IDLE) && start) || (state_reg == BUSY));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      f3_reg     <= '0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        count_reg  <= '0;
        f3_reg     <= funct3;
        neg_a_reg  <= neg_a_in;
        neg_b_reg  <= neg_b_in;
        b_zero_reg <= b_zero_in;
        ovf_reg    <= ovf_in;
      end else if (state_reg == BUSY) begin
        count_reg <= count_reg + 1'b1;
      end
      if (result_load) result_reg <= result_value;
    end
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (state_reg == BUSY),
    .mode    (f3_reg[2]),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  assign busy         = (state_reg == BUSY);
  assign result_valid = (state_reg == DONE);
  assign result       = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: 64-bit arithmetic reference model,
// directed RV32M corner cases, flush/reset aborts and randomized operations.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flush        (flush),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  localparam int NV = 15;
  localparam vec_t VECS [NV] = '{
    '{F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB},
    '{F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE},
    '{F3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000},
    '{F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF},
    '{F3_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001},
    '{F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD},
    '{F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF},
    '{F3_DIVU,   32'd7,          32'd2,        32'd3},
    '{F3_REMU,   32'd7,          32'd2,        32'd1},
    '{F3_DIV,    32'd5,          32'd0,        32'hFFFFFFFF},
    '{F3_REM,    32'd5,          32'd0,        32'd5},
    '{F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000},
    '{F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000},
    '{F3_REMU,   32'hFFFFFFF0,   32'd0,        32'hFFFFFFF0},
    '{F3_MULH,   32'd0,          32'h80000000, 32'h00000000}
  };

  // Reference: plain 64-bit arithmetic with the RV32M special-case rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      F3_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      F3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      F3_MULHU:  begin p = 64'(ua) * 64'(ub); return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = 64'(sa / sb); return p[31:0];
      end
      F3_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        p = 64'(sa % sb); return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
    if (f[2]) return (b == 0) || ((f == F3_DIV || f == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF);
    return (a == 0) || (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle expectations, written by the driver and consumed by the compare process.
  bit          chk_en = 1'b0;
  bit          e_stall, e_busy, e_valid, e_chk_res;
  logic [31:0] e_res, last_res;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < NV; i++)
      check($sformatf("model_pin%0d", i), model(VECS[i].f, VECS[i].a, VECS[i].b), VECS[i].r);
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("stall", 32'(stall), 32'(e_stall));
        check("busy", 32'(busy), 32'(e_busy));
        check("result_valid", 32'(result_valid), 32'(e_valid));
        if (e_chk_res) check("result", result, e_res);
      end
    end
  end

  task automatic set_exp(input bit s, input bit b, input bit v, input bit cr, input logic [31:0] r);
    e_stall = s; e_busy = b; e_valid = v; e_chk_res = cr; e_res = r;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      op_a = $urandom; op_b = $urandom;
      set_exp(0, 0, 0, 1, last_res);
    end
  endtask

  // abort_at: cycle index at which flush (or rst) is raised; -1 runs to completion.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_val, input int abort_at, input bit abort_rst);
    int lat;
    lat = is_fast(f, a, b) ? 1 : 33;
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b0; rst = 1'b0; funct3 = f; op_a = a; op_b = b;
    set_exp(1, 0, 0, 0, 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      if (k == abort_at) begin
        if (abort_rst) begin
          rst = 1'b1;
          set_exp(1, 1, 0, 0, 32'd0);
          @(posedge clk); #1;
          rst = 1'b0; start = 1'b0;
          last_res = 32'd0;
          set_exp(0, 0, 0, 1, 32'd0);
        end else begin
          flush = 1'b1;
          set_exp(0, 1, 0, 0, 32'd0);
        end
        $display("op f3=%0d a=%h b=%h aborted by %s at cycle %0d", f, a, b, abort_rst ? "rst" : "flush", k);
        return;
      end
      set_exp(k < lat, k < lat, k == lat, k == lat, exp_val);
    end
    last_res = exp_val;
    $display("op f3=%0d a=%h b=%h expect=%h latency=%0d", f, a, b, exp_val, lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    last_res = 32'd0;
    set_exp(0, 0, 0, 1, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    for (int i = 0; i < NV; i++) run_op(VECS[i].f, VECS[i].a, VECS[i].b, VECS[i].r, -1, 1'b0);
    idle(2);

    // flush in BUSY, then a back-to-back accept on the very next cycle
    run_op(F3_DIV, 32'd100, 32'd7, 32'd14, 10, 1'b0);
    run_op(F3_MUL, 32'h00012345, 32'h00000100, 32'h01234500, -1, 1'b0);
    idle(1);

    // start together with flush in IDLE is not accepted
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd3;
    set_exp(0, 0, 0, 1, last_res);
    idle(2);

    // reset in BUSY abandons the op and clears result
    run_op(F3_DIVU, 32'd1000, 32'd3, 32'd333, 20, 1'b1);
    idle(2);
    run_op(F3_REMU, 32'd1000, 32'd3, 32'd1, -1, 1'b0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(rf, ra, rb, model(rf, ra, rb), -1, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    @(posedge clk); #1;
    chk_en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
